ahb_lite_interconnect_n: RTL and testbench

Parametrised AHB-lite single-master to N-slave interconnect. It replaces the fixed 6-slave decoder/mux, which ties HREADY to 1.
It provides table-driven address decode, a registered data-phase select, and wait-state propagation from slave HREADYOUT.
It also adds a built-in default slave that returns the two-cycle ERROR response, and a stalled-slave watchdog. It sits between the MIPSfpga core bus and the RAM/GPIO/VRAM/SRAM/SD slaves.

---
 rtl/ahb_lite_interconnect_n_if.sv | 26 ++
 rtl/ahb_lite_interconnect_n.sv | 145 ++++++++++++++
 tb/tb_ahb_lite_interconnect_n.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_interconnect_n_if.sv
// AHB-lite bus bundle between one master, the interconnect and N slaves.
// The slave modport is the interconnect's view; the master modport is the bus side that feeds it.
interface ahb_lite_interconnect_n_if #(
  parameter int N_SLV  = 6,
  parameter int DATA_W = 32
);
  logic [31:0]             HADDR;
  logic [1:0]              HTRANS;
  logic [DATA_W-1:0]       HRDATA;
  logic                    HREADY;
  logic                    HRESP;
  logic [N_SLV-1:0]        HSEL_S;
  logic [N_SLV*DATA_W-1:0] HRDATA_S;
  logic [N_SLV-1:0]        HREADYOUT_S;
  logic [N_SLV-1:0]        HRESP_S;

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, HSEL_S
  );

  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP, HSEL_S
  );
endinterface

// File: rtl/ahb_lite_interconnect_n.sv
// Single-master to N-slave AHB-lite interconnect: table decode, registered data-phase
// select, wait-state propagation, built-in ERROR default slave and stalled-slave watchdog.
module ahb_lite_interconnect_n #(
  parameter int                  N_SLV    = 6,
  parameter int                  DATA_W   = 32,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'h0}},
  parameter int                  TIMEOUT  = 1024
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  ahb_lite_interconnect_n_if.slave bus,
  output logic                     TIMEOUT_IRQ,
  input  logic                     TIMEOUT_CLR,
  output logic [3:0]               TIMEOUT_SLV
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {S_IDLE, S_SLV, S_ERR1, S_ERR2, S_TO1, S_TO2} state_t;

  state_t            state_reg;
  logic [3:0]        dp_sel_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic              irq_reg;
  logic [3:0]        to_slv_reg;

  logic [N_SLV-1:0]  hit;
  logic [N_SLV-1:0]  dec_sel;
  logic [3:0]        hit_idx;
  logic              any_hit;
  logic [15:0]       ready_pad;
  logic [15:0]       resp_pad;
  logic [DATA_W-1:0] rdata_arr [16];
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  state_t            ap_state;

  // Slave inputs are padded to 16 entries so a 4-bit select can index them safely.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slv
      if (gi < N_SLV) begin : g_live
        assign hit[gi]       = ((bus.HADDR & SLV_MASK[32*gi +: 32]) ==
                                (SLV_BASE[32*gi +: 32] & SLV_MASK[32*gi +: 32]));
        assign ready_pad[gi] = bus.HREADYOUT_S[gi];
        assign resp_pad[gi]  = bus.HRESP_S[gi];
        assign rdata_arr[gi] = bus.HRDATA_S[DATA_W*gi +: DATA_W];
      end else begin : g_tie
        assign ready_pad[gi] = 1'b1;
        assign resp_pad[gi]  = 1'b0;
        assign rdata_arr[gi] = '0;
      end
    end
  endgenerate

  // Scan from the top so the lowest-indexed hit is the one that sticks.
  always_comb begin
    dec_sel = '0;
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        hit_idx    = 4'(i);
        any_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    if (bus.HTRANS[1] && any_hit)
      ap_state = S_SLV;
    else if (bus.HTRANS[1])
      ap_state = S_ERR1;
    else
      ap_state = S_IDLE;
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state_reg)
      S_SLV: begin
        hready = ready_pad[dp_sel_reg];
        hresp  = resp_pad[dp_sel_reg];
        hrdata = rdata_arr[dp_sel_reg];
      end
      S_ERR1, S_TO1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      S_ERR2, S_TO2: hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg    <= S_IDLE;
      dp_sel_reg   <= '0;
      wait_cnt_reg <= '0;
      irq_reg      <= 1'b0;
      to_slv_reg   <= '0;
    end else begin
      if (hready)
        dp_sel_reg <= hit_idx;
      // A timeout set later in this block overrides the clear.
      if (TIMEOUT_CLR)
        irq_reg <= 1'b0;
      case (state_reg)
        S_SLV: begin
          if (hready) begin
            state_reg    <= ap_state;
            wait_cnt_reg <= '0;
          end else if (WDOG_EN && wait_cnt_reg == CNT_LAST) begin
            state_reg    <= S_TO1;
            wait_cnt_reg <= '0;
            irq_reg      <= 1'b1;
            to_slv_reg   <= dp_sel_reg;
          end else if (wait_cnt_reg != '1) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        S_ERR1: state_reg <= S_ERR2;
        S_TO1:  state_reg <= S_TO2;
        default: begin
          state_reg    <= ap_state;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign bus.HSEL_S   = dec_sel;
  assign bus.HREADY   = hready;
  assign bus.HRESP    = hresp;
  assign bus.HRDATA   = hrdata;
  assign TIMEOUT_IRQ  = irq_reg;
  assign TIMEOUT_SLV  = to_slv_reg;
endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Bench for ahb_lite_interconnect_n: directed scenarios plus a randomized transfer
// stream checked against a per-transfer data-phase model.
module tb_ahb_lite_interconnect_n;
  localparam int N  = 6;
  localparam int DW = 32;
  localparam logic [N*32-1:0] BASES = {32'h10000000, 32'hC0000000, 32'hBF000000,
                                       32'hA0000000, 32'h80000000, 32'hBFC00000};
  localparam logic [N*32-1:0] MASKS = {32'hF0000000, 32'hF0000000, 32'hFF000000,
                                       32'hF0000000, 32'hF0000000, 32'hFF800000};

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          TIMEOUT_IRQ;
  logic          TIMEOUT_CLR;
  logic [3:0]    TIMEOUT_SLV;
  logic [DW-1:0] sdata [N];
  int            checks = 0;
  int            failures = 0;

  ahb_lite_interconnect_n_if #(.N_SLV(N), .DATA_W(DW)) bus ();

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sdata
      assign bus.HRDATA_S[DW*gi +: DW] = sdata[gi];
    end
  endgenerate

  ahb_lite_interconnect_n #(
    .N_SLV(N), .DATA_W(DW), .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(8)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus),
    .TIMEOUT_IRQ(TIMEOUT_IRQ),
    .TIMEOUT_CLR(TIMEOUT_CLR),
    .TIMEOUT_SLV(TIMEOUT_SLV)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.HADDR       = 32'h0;
    bus.HTRANS      = 2'd0;
    bus.HREADYOUT_S = '1;
    bus.HRESP_S     = '0;
    TIMEOUT_CLR     = 1'b0;
  endtask

  task automatic new_data();
    for (int j = 0; j < N; j++) sdata[j] = $urandom;
  endtask

  task automatic test_reset();
    idle_bus();
    new_data();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    checks++; if (bus.HREADY !== 1'b1) begin failures++; $display("FAIL reset_hready got=%b exp=1", bus.HREADY); end
    checks++; if (bus.HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); end
    checks++; if (TIMEOUT_IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", TIMEOUT_IRQ); end
    checks++; if (TIMEOUT_SLV !== 4'd0) begin failures++; $display("FAIL reset_to_slv got=%0d exp=0", TIMEOUT_SLV); end
    $display("reset: HREADY=%b HRESP=%b HRDATA=%h", bus.HREADY, bus.HRESP, bus.HRDATA);
  endtask

  task automatic test_decode();
    new_data();
    bus.HADDR = 32'h80000010; bus.HTRANS = 2'd2; #1;
    checks++; if (bus.HSEL_S !== 6'b000010) begin failures++; $display("FAIL dec_hsel1 got=%b exp=000010", bus.HSEL_S); end
    tick();
    bus.HADDR = 32'hBFC00004; #1;
    checks++; if (bus.HSEL_S !== 6'b000001) begin failures++; $display("FAIL dec_hsel0 got=%b exp=000001", bus.HSEL_S); end
    checks++; if (bus.HRDATA !== sdata[1]) begin failures++; $display("FAIL dec_data1 got=%h exp=%h", bus.HRDATA, sdata[1]); end
    checks++; if (bus.HRESP !== 1'b0) begin failures++; $display("FAIL dec_resp1 got=%b exp=0", bus.HRESP); end
    checks++; if (bus.HREADY !== 1'b1) begin failures++; $display("FAIL dec_ready1 got=%b exp=1", bus.HREADY); end
    tick();
    bus.HTRANS = 2'd0; #1;
    checks++; if (bus.HRDATA !== sdata[0]) begin failures++; $display("FAIL dec_data0 got=%h exp=%h", bus.HRDATA, sdata[0]); end
    checks++; if (bus.HRESP !== 1'b0) begin failures++; $display("FAIL dec_resp0 got=%b exp=0", bus.HRESP); end
    tick();
    #1;
    checks++; if (bus.HRDATA !== 32'h0) begin failures++; $display("FAIL dec_idle_data got=%h exp=0", bus.HRDATA); end
    $display("decode: 0x80000010 -> slv1, 0xBFC00004 -> slv0");
  endtask

  task automatic test_wait_states();
    int low;
    new_data();
    low = 0;
    bus.HADDR = 32'h80000000; bus.HTRANS = 2'd2; #1;
    tick();
    bus.HADDR = 32'hBFC00000; bus.HREADYOUT_S = 6'b111101;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.HREADY === 1'b0) low++;
      checks++; if (bus.HRDATA !== sdata[1]) begin failures++; $display("FAIL wait_dp_sel got=%h exp=%h", bus.HRDATA, sdata[1]); end
      tick();
    end
    bus.HREADYOUT_S = '1; #1;
    checks++; if (bus.HREADY !== 1'b1) begin failures++; $display("FAIL wait_release got=%b exp=1", bus.HREADY); end
    checks++; if (low !== 3) begin failures++; $display("FAIL wait_low_cycles got=%0d exp=3", low); end
    checks++; if (bus.HRDATA !== sdata[1]) begin failures++; $display("FAIL wait_final_data got=%h exp=%h", bus.HRDATA, sdata[1]); end
    tick();
    bus.HTRANS = 2'd0; #1;
    checks++; if (bus.HRDATA !== sdata[0]) begin failures++; $display("FAIL wait_held_addr got=%h exp=%h", bus.HRDATA, sdata[0]); end
    tick();
    $display("wait_states: slv1 stalled 3 cycles, HREADY low %0d cycles", low);
  endtask

  task automatic test_default_slave();
    new_data();
    bus.HADDR = 32'h40000000; bus.HTRANS = 2'd2; #1;
    checks++; if (bus.HSEL_S !== 6'b0) begin failures++; $display("FAIL def_hsel got=%b exp=000000", bus.HSEL_S); end
    tick();
    bus.HADDR = 32'hBFC00000; #1;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL def_err1 got=%b%b exp=01", bus.HREADY, bus.HRESP); end
    tick();
    #1;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL def_err2 got=%b%b exp=11", bus.HREADY, bus.HRESP); end
    tick();
    bus.HTRANS = 2'd0; #1;
    checks++; if (bus.HRDATA !== sdata[0] || bus.HRESP !== 1'b0 || bus.HREADY !== 1'b1) begin
      failures++; $display("FAIL def_next_xfer got=%h/%b/%b exp=%h/0/1", bus.HRDATA, bus.HRESP, bus.HREADY, sdata[0]);
    end
    tick();
    $display("default_slave: unmapped 0x40000000 -> two-cycle ERROR");
  endtask

  task automatic test_idle_unmapped();
    for (int t = 0; t < 2; t++) begin
      bus.HADDR = 32'h40000000; bus.HTRANS = 2'(t); #1;
      tick();
      bus.HTRANS = 2'd0; #1;
      checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
        failures++; $display("FAIL idle_unmapped htrans=%0d got=%b%b exp=10", t, bus.HREADY, bus.HRESP);
      end
      tick();
      $display("idle_unmapped: HTRANS=%0d to 0x40000000 -> OKAY", t);
    end
  endtask

  task automatic test_timeout();
    int waits;
    bus.HADDR = 32'hA0000000; bus.HTRANS = 2'd2; #1;
    tick();
    bus.HTRANS = 2'd0; bus.HADDR = 32'h0; bus.HREADYOUT_S = 6'b111011;
    waits = 0;
    while (waits < 40) begin
      #1;
      if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b0) break;
      waits++;
      tick();
    end
    checks++; if (waits !== 8) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=8", waits); end
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL to_to1 got=%b%b exp=01", bus.HREADY, bus.HRESP); end
    checks++; if (TIMEOUT_IRQ !== 1'b1) begin failures++; $display("FAIL to_irq got=%b exp=1", TIMEOUT_IRQ); end
    checks++; if (TIMEOUT_SLV !== 4'd2) begin failures++; $display("FAIL to_slv got=%0d exp=2", TIMEOUT_SLV); end
    tick();
    bus.HADDR = 32'hA0000000; bus.HTRANS = 2'd2; TIMEOUT_CLR = 1'b1; #1;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL to_to2 got=%b%b exp=11", bus.HREADY, bus.HRESP); end
    tick();
    TIMEOUT_CLR = 1'b0; bus.HTRANS = 2'd0;
    for (int w = 1; w <= 8; w++) begin
      #1;
      checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b0) begin failures++; $display("FAIL to2_wait w=%0d got=%b%b exp=00", w, bus.HREADY, bus.HRESP); end
      if (w == 1) begin
        checks++; if (TIMEOUT_IRQ !== 1'b0) begin failures++; $display("FAIL to_irq_clr got=%b exp=0", TIMEOUT_IRQ); end
      end
      if (w == 8) TIMEOUT_CLR = 1'b1;
      tick();
    end
    TIMEOUT_CLR = 1'b0; #1;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL to2_to1 got=%b%b exp=01", bus.HREADY, bus.HRESP); end
    checks++; if (TIMEOUT_IRQ !== 1'b1) begin failures++; $display("FAIL to_set_over_clr got=%b exp=1", TIMEOUT_IRQ); end
    tick();
    #1;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin failures++; $display("FAIL to2_to2 got=%b%b exp=11", bus.HREADY, bus.HRESP); end
    checks++; if (TIMEOUT_SLV !== 4'd2) begin failures++; $display("FAIL to2_slv got=%0d exp=2", TIMEOUT_SLV); end
    bus.HREADYOUT_S = '1;
    tick();
    $display("timeout: slv2 aborted after %0d waits, IRQ=%b SLV=%0d", waits, TIMEOUT_IRQ, TIMEOUT_SLV);
  endtask

  task automatic test_overlap_reset();
    new_data();
    bus.HADDR = 32'hBF800000; bus.HTRANS = 2'd2; #1;
    checks++; if (bus.HSEL_S !== 6'b000001) begin failures++; $display("FAIL ovl_hsel got=%b exp=000001", bus.HSEL_S); end
    tick();
    bus.HADDR = 32'hBF000010; #1;
    checks++; if (bus.HSEL_S !== 6'b001000) begin failures++; $display("FAIL ovl_hsel3 got=%b exp=001000", bus.HSEL_S); end
    tick();
    bus.HTRANS = 2'd0; bus.HREADYOUT_S = 6'b110111; #1;
    checks++; if (bus.HREADY !== 1'b0 || bus.HRDATA !== sdata[3]) begin
      failures++; $display("FAIL ovl_wait got=%b/%h exp=0/%h", bus.HREADY, bus.HRDATA, sdata[3]);
    end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0; #1;
    checks++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
      failures++; $display("FAIL ovl_reset got=%b/%b/%h exp=1/0/0", bus.HREADY, bus.HRESP, bus.HRDATA);
    end
    checks++; if (TIMEOUT_IRQ !== 1'b0) begin failures++; $display("FAIL ovl_reset_irq got=%b exp=0", TIMEOUT_IRQ); end
    bus.HREADYOUT_S = '1;
    tick();
    $display("overlap_reset: 0xBF800000 -> slv0 only, reset aborts slv3 wait");
  endtask

  // Each transfer's data phase is replayed while the next transfer's address phase is driven.
  task automatic test_random();
    int prev_kind, prev_idx, prev_waits, ncyc, r, exp_idx, waits;
    logic prev_resp, resp, exp_ready, exp_resp;
    logic [31:0] addr, exp_data;
    logic [1:0] trans;
    logic [N-1:0] exp_hsel;
    prev_kind = 0; prev_idx = 0; prev_waits = 0; prev_resp = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: addr = 32'hBFC00000 | ($urandom & 32'h003FFFFF);
        1: addr = 32'h80000000 | ($urandom & 32'h0FFFFFFF);
        2: addr = 32'hA0000000 | ($urandom & 32'h0FFFFFFF);
        3: addr = 32'hBF000000 | ($urandom & 32'h007FFFFF);
        4: addr = 32'hC0000000 | ($urandom & 32'h0FFFFFFF);
        5: addr = 32'h10000000 | ($urandom & 32'h0FFFFFFF);
        6: addr = 32'h40000000 | ($urandom & 32'h0FFFFFFF);
        default: addr = 32'hE0000000 | ($urandom & 32'h0FFFFFFF);
      endcase
      exp_idx  = r;
      exp_hsel = (r < N) ? N'(1 << r) : '0;
      trans    = (k == 40) ? 2'd0 : 2'($urandom_range(0, 3));
      waits    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
      resp     = ($urandom_range(0, 7) == 0);
      ncyc     = (prev_kind == 1) ? prev_waits + 1 : (prev_kind == 2) ? 2 : 1;
      for (int c = 0; c < ncyc; c++) begin
        bus.HADDR = addr; bus.HTRANS = trans;
        new_data();
        bus.HREADYOUT_S = N'($urandom);
        bus.HRESP_S     = N'($urandom);
        if (prev_kind == 1) begin
          bus.HREADYOUT_S[prev_idx] = (c == ncyc - 1);
          bus.HRESP_S[prev_idx]     = prev_resp;
        end
        exp_ready = (c == ncyc - 1);
        exp_resp  = (prev_kind == 2) ? 1'b1 : (prev_kind == 1) ? prev_resp : 1'b0;
        exp_data  = (prev_kind == 1) ? sdata[prev_idx] : 32'h0;
        #1;
        checks++; if (bus.HSEL_S !== exp_hsel) begin failures++; $display("FAIL rnd_hsel k=%0d got=%b exp=%b", k, bus.HSEL_S, exp_hsel); end
        checks++; if (bus.HREADY !== exp_ready) begin failures++; $display("FAIL rnd_hready k=%0d c=%0d got=%b exp=%b", k, c, bus.HREADY, exp_ready); end
        checks++; if (bus.HRESP !== exp_resp) begin failures++; $display("FAIL rnd_hresp k=%0d c=%0d got=%b exp=%b", k, c, bus.HRESP, exp_resp); end
        checks++; if (bus.HRDATA !== exp_data) begin failures++; $display("FAIL rnd_hrdata k=%0d c=%0d got=%h exp=%h", k, c, bus.HRDATA, exp_data); end
        tick();
      end
      $display("rnd k=%0d addr=%h htrans=%0d region=%0d prev_kind=%0d prev_slv=%0d cycles=%0d", k, addr, trans, r, prev_kind, prev_idx, ncyc);
      if (!trans[1]) prev_kind = 0;
      else if (exp_idx < N) begin prev_kind = 1; prev_idx = exp_idx; end
      else prev_kind = 2;
      prev_waits = waits;
      prev_resp  = resp;
    end
    checks++; if (TIMEOUT_IRQ !== 1'b0) begin failures++; $display("FAIL rnd_irq got=%b exp=0", TIMEOUT_IRQ); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_wait_states();
    test_default_slave();
    test_idle_unmapped();
    test_timeout();
    test_overlap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "simulation time limit");
  end
endmodule
